// File: rtl/axi_lite_cfg_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_cfg_slave_if
//  Description : AXI4-Lite bus bundle between the host and the accelerator
//                configuration/status port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_cfg_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    // Write address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    // Write data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    // Write response channel
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    // Read address channel
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    // Read data channel
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_cfg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_cfg_slave
//  Description : AXI4-Lite responder for the accelerator config/status port.
//                Host writes become one-cycle weight/bias strobes or update
//                the layer/neuron registers; reads return the classification
//                result and a wrapping stream of final-layer neuron outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_cfg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int dataWidth          = 16,
    parameter int numOutNeurons      = 10
) (
    input  wire logic                                s_axi_aclk,
    input  wire logic                                s_axi_aresetn,
    axi_lite_cfg_slave_if.slave                      s_axi,
    output logic                                     weightValid,
    output logic [31:0]                              weightValue,
    output logic                                     biasValid,
    output logic [31:0]                              biasValue,
    output logic [31:0]                              layerNumber,
    output logic [31:0]                              neuronNumber,
    input  wire logic [31:0]                         result,
    input  wire logic                                resultValid,
    input  wire logic [numOutNeurons*dataWidth-1:0]  neuronOut,
    output logic                                     intr
);

    // Word-select codes (byte address bits [4:2])
    localparam logic [2:0] c_SEL_WEIGHT = 3'd0;
    localparam logic [2:0] c_SEL_BIAS   = 3'd1;
    localparam logic [2:0] c_SEL_RESULT = 3'd2;
    localparam logic [2:0] c_SEL_LAYER  = 3'd3;
    localparam logic [2:0] c_SEL_NEURON = 3'd4;
    localparam logic [2:0] c_SEL_STREAM = 3'd5;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    localparam int PTR_W = (numOutNeurons > 1) ? $clog2(numOutNeurons) : 1;
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(numOutNeurons - 1);

    typedef enum logic [0:0] { W_IDLE = 1'b0, W_RESP = 1'b1 } wr_state_t;
    typedef enum logic [0:0] { R_IDLE = 1'b0, R_DATA = 1'b1 } rd_state_t;

    wr_state_t   wr_state_q;
    rd_state_t   rd_state_q;

    logic        awready_q;
    logic        wready_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [2:0]  rd_sel_q;

    logic        weightValid_q;
    logic [31:0] weightValue_q;
    logic        biasValid_q;
    logic [31:0] biasValue_q;
    logic [31:0] layer_q;
    logic [31:0] neuron_q;
    logic [31:0] result_q;
    logic        intr_q;
    logic [PTR_W-1:0] ptr_q;

    logic [dataWidth-1:0]          slice_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_d;
    logic [1:0]                    rresp_d;
    logic                          r_hs_d;

    // Protection bits and byte-lane address bits carry no meaning here
    wire w_unused_ok = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign weightValid  = weightValid_q;
    assign weightValue  = weightValue_q;
    assign biasValid    = biasValid_q;
    assign biasValue    = biasValue_q;
    assign layerNumber  = layer_q;
    assign neuronNumber = neuron_q;
    assign intr         = intr_q;

    assign r_hs_d = rvalid_q & s_axi.rready;

    // Select the neuron output addressed by the stream pointer
    always_comb begin
        slice_d = '0;
        for (int i = 0; i < numOutNeurons; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                slice_d = neuronOut[i*dataWidth +: dataWidth];
            end
        end
    end

    // Read data/response for the address presented on AR
    always_comb begin
        rdata_d = '0;
        rresp_d = c_RESP_OKAY;
        case (s_axi.araddr[4:2])
            c_SEL_WEIGHT: rdata_d = weightValue_q;
            c_SEL_BIAS:   rdata_d = biasValue_q;
            c_SEL_RESULT: rdata_d = result_q;
            c_SEL_LAYER:  rdata_d = layer_q;
            c_SEL_NEURON: rdata_d = neuron_q;
            c_SEL_STREAM: rdata_d = C_S_AXI_DATA_WIDTH'(slice_d);
            default:      rresp_d = c_RESP_SLVERR;
        endcase
    end

    // Write FSM: ready pulse on both valids, apply effect, hold B until taken
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state_q    <= W_IDLE;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= c_RESP_OKAY;
            weightValid_q <= 1'b0;
            weightValue_q <= '0;
            biasValid_q   <= 1'b0;
            biasValue_q   <= '0;
            layer_q       <= '0;
            neuron_q      <= '0;
        end else begin
            weightValid_q <= 1'b0;
            biasValid_q   <= 1'b0;
            case (wr_state_q)
                W_IDLE: begin
                    if (awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (s_axi.awvalid && s_axi.wvalid) begin
                            bvalid_q   <= 1'b1;
                            bresp_q    <= c_RESP_OKAY;
                            wr_state_q <= W_RESP;
                            case (s_axi.awaddr[4:2])
                                c_SEL_WEIGHT: begin
                                    weightValid_q <= 1'b1;
                                    weightValue_q <= s_axi.wdata;
                                end
                                c_SEL_BIAS: begin
                                    biasValid_q <= 1'b1;
                                    biasValue_q <= s_axi.wdata;
                                end
                                c_SEL_LAYER: begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (s_axi.wstrb[b]) begin
                                            layer_q[8*b +: 8] <= s_axi.wdata[8*b +: 8];
                                        end
                                    end
                                end
                                c_SEL_NEURON: begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (s_axi.wstrb[b]) begin
                                            neuron_q[8*b +: 8] <= s_axi.wdata[8*b +: 8];
                                        end
                                    end
                                end
                                default: bresp_q <= c_RESP_SLVERR;
                            endcase
                        end
                    end else if (s_axi.awvalid && s_axi.wvalid) begin
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: one-cycle AR ready, then registered R held until taken
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= c_RESP_OKAY;
            rd_sel_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arready_q) begin
                        arready_q <= 1'b0;
                        if (s_axi.arvalid) begin
                            rvalid_q   <= 1'b1;
                            rdata_q    <= rdata_d;
                            rresp_q    <= rresp_d;
                            rd_sel_q   <= s_axi.araddr[4:2];
                            rd_state_q <= R_DATA;
                        end
                    end else if (s_axi.arvalid) begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q   <= 1'b0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    // Result latch, interrupt and stream pointer; a new result wins over a clear
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            result_q <= '0;
            intr_q   <= 1'b0;
            ptr_q    <= '0;
        end else if (resultValid) begin
            result_q <= result;
            intr_q   <= 1'b1;
            ptr_q    <= '0;
        end else if (r_hs_d) begin
            if (rd_sel_q == c_SEL_RESULT) begin
                intr_q <= 1'b0;
            end
            if (rd_sel_q == c_SEL_STREAM) begin
                ptr_q <= (ptr_q == c_PTR_LAST) ? '0 : ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cfg_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_cfg_slave
//  Description : Directed self-checking bench for axi_lite_cfg_slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_cfg_slave;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         weightValid, biasValid, intr, resultValid;
    logic [31:0]  weightValue, biasValue, layerNumber, neuronNumber, result;
    logic [159:0] neuronOut;

    int checks = 0;
    int errors = 0;

    int          wr_pulses = 0;
    int          wv_pulses = 0;
    int          bv_pulses = 0;
    int          wv_double = 0;
    logic        wv_prev   = 1'b0;
    logic [31:0] wv_last   = '0;
    logic [31:0] bv_last   = '0;

    always #5 clk = ~clk;

    axi_lite_cfg_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

    axi_lite_cfg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .dataWidth(16),
        .numOutNeurons(10)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .s_axi        (bus),
        .weightValid  (weightValid),
        .weightValue  (weightValue),
        .biasValid    (biasValid),
        .biasValue    (biasValue),
        .layerNumber  (layerNumber),
        .neuronNumber (neuronNumber),
        .result       (result),
        .resultValid  (resultValid),
        .neuronOut    (neuronOut),
        .intr         (intr)
    );

    // Strobe/ready observers sampled on the inactive edge
    always @(negedge clk) begin
        if (bus.wready) wr_pulses++;
        if (weightValid) begin
            wv_pulses++;
            wv_last = weightValue;
            if (wv_prev) wv_double++;
        end
        wv_prev = weightValid;
        if (biasValid) begin
            bv_pulses++;
            bv_last = biasValue;
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] st, output logic [1:0] resp);
        int n;
        resp = 2'bxx;
        @(negedge clk);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL write_accept_timeout addr=%h got=no_ready exp=ready", a);
        end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        n = 0;
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL write_bvalid_timeout addr=%h got=no_bvalid exp=bvalid", a);
        end
        resp = bus.bresp;
        @(posedge clk);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        d = 'x; resp = 2'bxx;
        @(negedge clk);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL read_accept_timeout addr=%h got=no_arready exp=arready", a);
        end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL read_rvalid_timeout addr=%h got=no_rvalid exp=rvalid", a);
        end
        d = bus.rdata; resp = bus.rresp;
        @(posedge clk);
    endtask

    task automatic pulse_result();
        @(negedge clk); resultValid = 1'b1;
        @(negedge clk); resultValid = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, weightValid, biasValid, intr} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000000",
                     {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, weightValid, biasValid, intr});
        end
        checks++;
        if ({weightValue, biasValue, layerNumber, neuronNumber, bus.rdata} !== 160'h0) begin
            errors++;
            $display("FAIL reset_regs got=%h exp=0", {weightValue, biasValue, layerNumber, neuronNumber, bus.rdata});
        end
        checks++;
        if ({bus.bresp, bus.rresp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_resp got=%b exp=0000", {bus.bresp, bus.rresp});
        end
    endtask

    task automatic test_layer_neuron();
        logic [1:0] r; logic [31:0] d; int p0;
        p0 = wr_pulses;
        axi_write(5'h0C, 32'd3, 4'hF, r);
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL layer_bresp got=%b exp=00", r); end
        checks++; if (wr_pulses - p0 !== 1) begin errors++; $display("FAIL layer_wready_pulses got=%0d exp=1", wr_pulses - p0); end
        p0 = wr_pulses;
        axi_write(5'h10, 32'd7, 4'hF, r);
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL neuron_bresp got=%b exp=00", r); end
        checks++; if (wr_pulses - p0 !== 1) begin errors++; $display("FAIL neuron_wready_pulses got=%0d exp=1", wr_pulses - p0); end
        checks++; if (layerNumber !== 32'd3) begin errors++; $display("FAIL layer_value got=%h exp=3", layerNumber); end
        checks++; if (neuronNumber !== 32'd7) begin errors++; $display("FAIL neuron_value got=%h exp=7", neuronNumber); end
        axi_read(5'h0C, d, r);
        checks++; if ({r, d} !== {2'b00, 32'd3}) begin errors++; $display("FAIL layer_read got=%b/%h exp=00/3", r, d); end
        axi_read(5'h10, d, r);
        checks++; if ({r, d} !== {2'b00, 32'd7}) begin errors++; $display("FAIL neuron_read got=%b/%h exp=00/7", r, d); end
        // Byte lanes 0 and 2 only: old value 0x00000003
        axi_write(5'h0C, 32'hAABBCCDD, 4'b0101, r);
        @(negedge clk);
        checks++; if (layerNumber !== 32'h00BB00DD) begin errors++; $display("FAIL layer_wstrb got=%h exp=00bb00dd", layerNumber); end
        axi_write(5'h0C, 32'd3, 4'hF, r);
    endtask

    task automatic test_weight_bias();
        logic [1:0] r; logic [31:0] d; int p0; int nerr;
        p0 = wv_pulses;
        axi_write(5'h00, 32'h1234, 4'hF, r);
        @(negedge clk);
        checks++; if (wv_pulses - p0 !== 1 || wv_last !== 32'h1234) begin
            errors++; $display("FAIL weight_single got=%0d/%h exp=1/1234", wv_pulses - p0, wv_last); end
        checks++; if (r !== 2'b00) begin errors++; $display("FAIL weight_bresp got=%b exp=00", r); end
        p0 = wv_pulses; nerr = 0;
        for (int i = 0; i < 784; i++) begin
            axi_write(5'h00, 32'(i), 4'hF, r);
            if (r !== 2'b00) nerr++;
        end
        @(negedge clk);
        checks++; if (wv_pulses - p0 !== 784 || nerr !== 0) begin
            errors++; $display("FAIL weight_burst got=%0d/%0d exp=784/0", wv_pulses - p0, nerr); end
        checks++; if (wv_double !== 0 || wv_last !== 32'd783) begin
            errors++; $display("FAIL weight_pulse_width got=%0d/%h exp=0/30f", wv_double, wv_last); end
        axi_write(5'h00, 32'hCAFE, 4'h0, r);
        @(negedge clk);
        checks++; if (weightValue !== 32'hCAFE) begin errors++; $display("FAIL weight_ignores_wstrb got=%h exp=cafe", weightValue); end
        p0 = bv_pulses;
        axi_write(5'h04, 32'h5678, 4'hF, r);
        @(negedge clk);
        checks++; if (bv_pulses - p0 !== 1 || bv_last !== 32'h5678 || r !== 2'b00) begin
            errors++; $display("FAIL bias_write got=%0d/%h/%b exp=1/5678/00", bv_pulses - p0, bv_last, r); end
        axi_read(5'h00, d, r);
        checks++; if (d !== 32'hCAFE) begin errors++; $display("FAIL weight_readback got=%h exp=cafe", d); end
        axi_read(5'h04, d, r);
        checks++; if (d !== 32'h5678) begin errors++; $display("FAIL bias_readback got=%h exp=5678", d); end
    endtask

    task automatic test_result();
        logic [1:0] r; logic [31:0] d; int n;
        result = 32'd2;
        pulse_result();
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL intr_set got=%b exp=1", intr); end
        axi_read(5'h08, d, r);
        checks++; if ({r, d} !== {2'b00, 32'd2}) begin errors++; $display("FAIL result_read got=%b/%h exp=00/2", r, d); end
        @(negedge clk);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL intr_clear got=%b exp=0", intr); end
        // New result arriving on the same edge as the clearing R handshake
        pulse_result();
        @(negedge clk);
        bus.araddr = 5'h08; bus.arvalid = 1'b1; bus.rready = 1'b0;
        n = 0;
        while (!bus.arready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        while (!bus.rvalid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) begin checks++; errors++; $display("FAIL setwins_timeout got=no_rvalid exp=rvalid"); end
        bus.rready = 1'b1; resultValid = 1'b1;
        @(negedge clk);
        resultValid = 1'b0;
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL intr_set_wins got=%b exp=1", intr); end
        axi_read(5'h08, d, r);
        @(negedge clk);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL intr_clear2 got=%b exp=0", intr); end
    endtask

    task automatic test_stream();
        logic [1:0] r; logic [31:0] d; int nerr;
        pulse_result();
        nerr = 0;
        for (int i = 0; i < 12; i++) begin
            axi_read(5'h14, d, r);
            if ({r, d} !== {2'b00, 32'h10 + 32'(i % 10)}) begin
                nerr++;
                $display("FAIL stream_read_%0d got=%b/%h exp=00/%h", i, r, d, 32'h10 + 32'(i % 10));
            end
        end
        checks++; if (nerr !== 0) errors++;
        axi_read(5'h14, d, r);
        pulse_result();
        axi_read(5'h14, d, r);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL stream_ptr_reset got=%h exp=10", d); end
    endtask

    task automatic test_errors();
        logic [1:0] r; logic [31:0] d;
        axi_write(5'h08, 32'hDEAD, 4'hF, r);
        @(negedge clk);
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_result_bresp got=%b exp=10", r); end
        checks++; if (layerNumber !== 32'd3 || neuronNumber !== 32'd7) begin
            errors++; $display("FAIL wr_err_side_effect got=%h/%h exp=3/7", layerNumber, neuronNumber); end
        axi_read(5'h08, d, r);
        checks++; if (d !== 32'd2) begin errors++; $display("FAIL result_after_err got=%h exp=2", d); end
        axi_write(5'h14, 32'h1, 4'hF, r);
        checks++; if (r !== 2'b10) begin errors++; $display("FAIL wr_stream_bresp got=%b exp=10", r); end
        axi_read(5'h1C, d, r);
        checks++; if ({r, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL rd_unmapped got=%b/%h exp=10/0", r, d); end
    endtask

    task automatic test_handshake();
        int bad; int n;
        @(negedge clk);
        bus.awaddr = 5'h0C; bus.wdata = 32'd9; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bad = 0;
        repeat (3) begin @(negedge clk); if (bus.awready || bus.wready) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL aw_only_ready got=%0d exp=0", bad); end
        bus.wvalid = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.awaddr = 5'h10; bus.wdata = 32'h55;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!bus.bvalid || bus.awready || bus.wready) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bvalid_hold got=%0d exp=0", bad); end
        checks++; if (layerNumber !== 32'd9) begin errors++; $display("FAIL delayed_write got=%h exp=9", layerNumber); end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        n = 0;
        while (!(bus.awready && bus.wready) && n < 20) begin @(negedge clk); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL second_write_accept got=no_ready exp=ready"); end
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++; if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL second_bvalid got=%b exp=1", bus.bvalid); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.bvalid !== 1'b0 || neuronNumber !== 32'd0) begin
            errors++; $display("FAIL async_reset got=%b/%h exp=0/0", bus.bvalid, neuronNumber); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.bready = 1'b1;
        bad = 0;
        repeat (3) begin @(negedge clk); if (bus.bvalid || bus.rvalid) bad++; end
        checks++; if (bad !== 0) begin errors++; $display("FAIL late_valid got=%0d exp=0", bad); end
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
        result = '0; resultValid = 1'b0;
        for (int i = 0; i < 10; i++) neuronOut[i*16 +: 16] = 16'h10 + 16'(i);
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_layer_neuron();
        test_weight_bias();
        test_result();
        test_stream();
        test_errors();
        test_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_cfg_slave.md
Name: axi_lite_cfg_slave

Overview:
AXI4-Lite responder (slave) end of the accelerator's configuration/status port. It accepts host writes of layer number, neuron number, weights and biases, and turns them into single-cycle config strobes for the neuron array. It returns the classification result and per-neuron outputs on reads, and drives the completion interrupt. It sits inside nn_autoGen_top between the AXI-Lite pins and the layer/maxFinder logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 5, AXI address width; addr[1:0] ignored
dataWidth, 16, width of one neuron output
numOutNeurons, 10, number of final-layer neuron outputs readable at 0x14

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  asynchronous active-low reset
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
s_axi_awprot  in  3  ignored
s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid / s_axi_wready  in / out  1  W handshake
s_axi_bresp  out  2  write response
s_axi_bvalid / s_axi_bready  out / in  1  B handshake
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
s_axi_arprot  in  3  ignored
s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid / s_axi_rready  out / in  1  R handshake
weightValid  out  1  one-cycle strobe, write to 0x00
weightValue  out  32  data captured with weightValid
biasValid  out  1  one-cycle strobe, write to 0x04
biasValue  out  32  data captured with biasValid
layerNumber  out  32  register 0x0C
neuronNumber  out  32  register 0x10
result  in  32  detected class from maxFinder
resultValid  in  1  one-cycle pulse, result and neuronOut are stable
neuronOut  in  numOutNeurons*dataWidth  flattened final-layer outputs; neuron 0 in LSBs
intr  out  1  completion interrupt

Behaviour:
- Reset (aresetn=0, asynchronous): all ready/valid outputs are 0; bresp=rresp=0; rdata=0; weightValid=biasValid=0; weightValue, biasValue, layerNumber and neuronNumber are 0; intr=0; read pointer=0; result latch=0.
- Register map (byte addr): 0x00 W weight; 0x04 W bias; 0x08 R result; 0x0C RW layer; 0x10 RW neuron; 0x14 R neuron-output stream. Reads of 0x00/0x04 return the last written value.
- Write channel: write FSM states IDLE -> RESP.
  - In IDLE with awvalid&wvalid both 1, assert awready=wready=1 for exactly one cycle and move to RESP.
  - Writes need both channels. AW without W, or W without AW, waits with no ready.
  - The cycle after the accept, bvalid=1. Hold it until bvalid&bready, then return to IDLE.
  - No new write is accepted while bvalid=1.
- Write effect, taking place in the accept cycle + 1 (same cycle bvalid rises):
  - 0x00: weightValid=1 for exactly one cycle, weightValue=wdata.
  - 0x04: same, on biasValid/biasValue.
  - 0x0C and 0x10: byte-masked by wstrb.
  - 0x00/0x04 ignore wstrb.
  - bresp=OKAY(00) for 0x00/04/0C/10. SLVERR(10) for 0x08, 0x14 and unmapped addresses, with no side effect.
- Read channel: read FSM states IDLE -> DATA.
  - In IDLE with arvalid=1, arready=1 for one cycle.
  - The next cycle rvalid=1 with rdata/rresp registered. Hold stable until rvalid&rready, then return to IDLE.
  - A read and a write may be in flight simultaneously and proceed independently.
- Read data:
  - 0x08 returns the result latch.
  - 0x14 returns the neuronOut slice at the read pointer, zero-extended to 32 bits. The pointer increments on the R handshake and wraps from numOutNeurons-1 to 0.
  - Unmapped addresses return 0 with SLVERR.
- resultValid: latch result and set intr=1 the next cycle. Reset the read pointer to 0.
  - A completed R handshake of 0x08 clears intr.
  - If resultValid and that clearing handshake coincide, intr stays 1 (set wins).
- Reset mid-transaction abandons it. No late bvalid/rvalid is issued after reset release.

Test Plan:
- Write 0x0C=3, then 0x10=7 -> each bresp=00, one wready pulse each; layerNumber=3, neuronNumber=7; reads return 3 and 7.
- Write 0x00=0x1234 back-to-back with bready held high -> weightValid high exactly one cycle with weightValue=0x1234; 784 consecutive writes produce 784 pulses.
- Pulse resultValid with result=2 -> intr=1 next cycle; read 0x08 returns 2 with rresp=00; intr=0 after the R handshake.
- neuronOut slices = 0x10..0x19; 12 reads of 0x14 -> 0x10..0x19, 0x10, 0x11 (wrap); a resultValid pulse resets the next read to 0x10.
- Write 0x08 and read 0x1C -> bresp=10 with no register change; rdata=0 with rresp=10.
- awvalid raised 3 cycles before wvalid, and bready delayed 5 cycles -> no ready until both valid; bvalid held 5 cycles; a second write is not accepted until the B handshake; reset asserted during RESP clears bvalid immediately.
